// File: rtl/gearbox_128_132.sv
`default_nettype none
// ============================================================================
// Module      : gearbox_128_132
// Description : Receive-side rate-matching gearbox. Packs a stream of 128-bit
//               lane words into 132-bit blocks, LSB-first (older bits low).
//               Every 33 accepted input words yield exactly 32 output words;
//               the single bubble happens when the residue is empty.
// Ports       : clk, rst (async, active-high)
//               resync          - drop residue and pending output, restart
//               din_valid/din/din_ready    - 128-bit input handshake
//               dout_valid/dout/dout_ready - 132-bit output handshake
//               phase           - residue count in nibbles (0..32), debug
// Revision    : 1.0 - initial release
// ============================================================================
module gearbox_128_132 #(
    parameter int IN_W  = 128,
    parameter int OUT_W = 132,
    parameter int PH_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              resync,
    input  logic              din_valid,
    input  logic [IN_W-1:0]   din,
    output logic              din_ready,
    input  logic              dout_ready,
    output logic              dout_valid,
    output logic [OUT_W-1:0]  dout,
    output logic [PH_W-1:0]   phase
);

    localparam int              c_comb_w = IN_W + OUT_W;
    localparam logic [PH_W-1:0] c_full_ph = PH_W'(IN_W / 4);

    logic [IN_W-1:0]   r_res;
    logic [PH_W-1:0]   r_ph;
    logic [OUT_W-1:0]  r_dout;
    logic              r_dout_valid;

    logic [PH_W+1:0]     w_shamt;
    logic [IN_W-1:0]     w_mask;
    logic [c_comb_w-1:0] w_comb;
    logic                w_ph_zero;
    logic                w_acc;
    logic                w_drain;

    assign w_ph_zero = (r_ph == '0);
    assign w_shamt   = {r_ph, 2'b00};

    // Residue bits above 4*ph are stale; the mask keeps them out of dout.
    // A shift by the full width (ph==32) yields zero, i.e. an all-ones mask.
    assign w_mask = ~({IN_W{1'b1}} << w_shamt);
    assign w_comb = {{OUT_W{1'b0}}, r_res & w_mask}
                  | ({{OUT_W{1'b0}}, din} << w_shamt);

    // With an empty residue the word only loads res, so it may be taken even
    // while an output is stalled.
    assign din_ready = !rst && !resync
                     && (w_ph_zero || !r_dout_valid || dout_ready);

    assign w_acc   = din_valid && din_ready;
    assign w_drain = r_dout_valid && dout_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res        <= '0;
            r_ph         <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (resync) begin
            r_res        <= '0;
            r_ph         <= '0;
            r_dout_valid <= 1'b0;
        end else if (w_acc) begin
            if (w_ph_zero) begin
                r_res        <= din;
                r_ph         <= c_full_ph;
                r_dout_valid <= r_dout_valid && !w_drain;
            end else begin
                // Each output consumes 132 bits, i.e. one nibble more than
                // was added, so the residue shrinks by one nibble per word.
                r_dout       <= w_comb[OUT_W-1:0];
                r_dout_valid <= 1'b1;
                r_res        <= w_comb[c_comb_w-1:OUT_W];
                r_ph         <= r_ph - PH_W'(1);
            end
        end else begin
            r_dout_valid <= r_dout_valid && !w_drain;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign phase      = r_ph;

endmodule
`default_nettype wire
